// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: turns bridge bytes into register-file read/write strobes,
// with burst auto-increment and a sticky invalid-address flag per transaction.
module spi_cmd_decoder #(
  parameter int unsigned ADDR_W   = 6,
  parameter int unsigned NUM_REGS = 16
) (
  input  logic              sclk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              byte_sync,
  input  logic [7:0]        rx_byte,
  output logic [7:0]        tx_byte,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_hi,
  output logic              reg_we,
  output logic [7:0]        reg_wdata,
  output logic              reg_re,
  input  logic [15:0]       reg_rdata,
  output logic              addr_err
);

  localparam logic [ADDR_W:0]   LP_NUM  = (ADDR_W+1)'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(NUM_REGS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ_FETCH,
    S_DATA
  } state_t;

  state_t            r_state;
  logic              r_rw;
  logic              r_hi;
  logic [ADDR_W-1:0] r_addr;
  logic              r_err;
  logic [7:0]        r_tx;
  logic              r_we;
  logic [7:0]        r_wdata;
  logic              r_re;
  logic              r_inc;

  logic              w_addr_ok;
  logic              w_cmd_bad;
  logic [ADDR_W-1:0] w_addr_next;
  logic              w_next_bad;
  logic              w_inc_now;

  assign w_addr_ok   = ({1'b0, r_addr} < LP_NUM);
  assign w_cmd_bad   = ({1'b0, rx_byte[ADDR_W-1:0]} >= LP_NUM);
  assign w_addr_next = (r_addr == LP_LAST) ? '0 : r_addr + 1'b1;
  assign w_next_bad  = ({1'b0, w_addr_next} >= LP_NUM);
  // Writes advance the address one cycle after the strobe's byte; reads advance on the byte edge.
  assign w_inc_now   = r_inc || (r_state == S_DATA && byte_sync && !r_rw);

  // Control state and strobes: cleared asynchronously by reset or by cs_n going high.
  always_ff @(posedge sclk or negedge rst_n or posedge cs_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_inc   <= 1'b0;
    end else if (cs_n) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_re    <= 1'b0;
      r_inc   <= 1'b0;
    end else begin
      r_we  <= 1'b0;
      r_re  <= 1'b0;
      r_inc <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (byte_sync) begin
            r_state <= rx_byte[7] ? S_DATA : S_READ_FETCH;
            r_re    <= !rx_byte[7];
          end
        end
        S_READ_FETCH: r_state <= S_DATA;
        S_DATA: begin
          if (byte_sync) begin
            if (r_rw) begin
              r_we  <= w_addr_ok;
              r_inc <= 1'b1;
            end else begin
              r_state <= S_READ_FETCH;
              r_re    <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Datapath registers hold their values across frames; only reset clears them.
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rw    <= 1'b0;
      r_hi    <= 1'b0;
      r_addr  <= '0;
      r_err   <= 1'b0;
      r_tx    <= '0;
      r_wdata <= '0;
    end else begin
      if (r_state == S_IDLE && byte_sync && !cs_n) begin
        r_rw   <= rx_byte[7];
        r_hi   <= rx_byte[6];
        r_addr <= rx_byte[ADDR_W-1:0];
        r_err  <= w_cmd_bad;
      end
      if (r_state == S_READ_FETCH) begin
        r_tx <= !w_addr_ok ? 8'h00 : (r_hi ? reg_rdata[15:8] : reg_rdata[7:0]);
      end
      if (r_state == S_DATA && byte_sync && r_rw && w_addr_ok) begin
        r_wdata <= rx_byte;
      end
      if (w_inc_now) begin
        r_addr <= w_addr_next;
        r_err  <= r_err | w_next_bad;
      end
    end
  end

  assign tx_byte   = r_tx;
  assign reg_addr  = r_addr;
  assign reg_hi    = r_hi;
  assign reg_we    = r_we;
  assign reg_wdata = r_wdata;
  assign reg_re    = r_re;
  assign addr_err  = r_err;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: write, read, burst wrap, invalid address,
// abort by cs_n and reset mid-burst, with a static register-file model.
module tb_spi_cmd_decoder;

  logic        sclk;
  logic        rst_n;
  logic        cs_n;
  logic        byte_sync;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_byte;
  logic [5:0]  reg_addr;
  logic        reg_hi;
  logic        reg_we;
  logic [7:0]  reg_wdata;
  logic        reg_re;
  logic [15:0] reg_rdata;
  logic        addr_err;

  int checks   = 0;
  int failures = 0;
  int we_count = 0;
  int both_count = 0;

  logic [15:0] mem [16];

  spi_cmd_decoder #(.ADDR_W(6), .NUM_REGS(16)) dut (
    .sclk      (sclk),
    .rst_n     (rst_n),
    .cs_n      (cs_n),
    .byte_sync (byte_sync),
    .rx_byte   (rx_byte),
    .tx_byte   (tx_byte),
    .reg_addr  (reg_addr),
    .reg_hi    (reg_hi),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .addr_err  (addr_err)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Out-of-range addresses read as all-ones so a zeroed tx_byte is distinguishable.
  always_comb begin
    reg_rdata = 16'hFFFF;
    if (reg_addr < 6'd16) reg_rdata = mem[reg_addr[3:0]];
  end

  always @(posedge sclk) begin
    if (reg_we) we_count <= we_count + 1;
    if (reg_we && reg_re) both_count <= both_count + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge sclk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    byte_sync = 1'b1;
    rx_byte   = b;
    @(posedge sclk);
    #1;
    byte_sync = 1'b0;
  endtask

  task automatic frame_start();
    cs_n = 1'b0;
    tick(2);
  endtask

  task automatic frame_end();
    cs_n = 1'b1;
    tick(2);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_tx"},    {8'h00, tx_byte},   16'h0000);
    chk({tag, "_addr"},  {10'h0, reg_addr},  16'h0000);
    chk({tag, "_hi"},    {15'h0, reg_hi},    16'h0000);
    chk({tag, "_we"},    {15'h0, reg_we},    16'h0000);
    chk({tag, "_wdata"}, {8'h00, reg_wdata}, 16'h0000);
    chk({tag, "_re"},    {15'h0, reg_re},    16'h0000);
    chk({tag, "_err"},   {15'h0, addr_err},  16'h0000);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 16'h0101 * i[15:0];
    mem[3] = 16'h12C4;
    mem[4] = 16'hBEEF;
    mem[5] = 16'h3C7E;
    mem[7] = 16'hA1B2;

    rst_n = 1'b0; cs_n = 1'b1; byte_sync = 1'b0; rx_byte = 8'h00;
    tick(3);
    chk_reset("rst0");
    rst_n = 1'b1;
    tick(2);

    // Single write: cmd 0x83, data 0xA5
    frame_start();
    send(8'h83);
    chk("wr_cmd_we", {15'h0, reg_we}, 16'h0000);
    chk("wr_cmd_addr", {10'h0, reg_addr}, 16'h0003);
    tick(7);
    send(8'hA5);
    chk("wr_we", {15'h0, reg_we}, 16'h0001);
    chk("wr_addr", {10'h0, reg_addr}, 16'h0003);
    chk("wr_hi", {15'h0, reg_hi}, 16'h0000);
    chk("wr_wdata", {8'h00, reg_wdata}, 16'h00A5);
    chk("wr_re", {15'h0, reg_re}, 16'h0000);
    tick();
    chk("wr_we_off", {15'h0, reg_we}, 16'h0000);
    chk("wr_addr_inc", {10'h0, reg_addr}, 16'h0004);
    chk("wr_err", {15'h0, addr_err}, 16'h0000);
    frame_end();

    // Single read, upper byte of reg 3, then a burst continuation to reg 4
    frame_start();
    send(8'h43);
    chk("rd_re", {15'h0, reg_re}, 16'h0001);
    chk("rd_we", {15'h0, reg_we}, 16'h0000);
    tick();
    chk("rd_tx", {8'h00, tx_byte}, 16'h0012);
    chk("rd_re_off", {15'h0, reg_re}, 16'h0000);
    tick(6);
    send(8'h00);
    chk("rd2_addr", {10'h0, reg_addr}, 16'h0004);
    chk("rd2_re", {15'h0, reg_re}, 16'h0001);
    tick();
    chk("rd2_tx", {8'h00, tx_byte}, 16'h00BE);
    frame_end();
    chk("rd_no_we", we_count[15:0], 16'd1);

    // Burst write with wrap 15 -> 0
    frame_start();
    send(8'h8F);
    tick(7);
    send(8'h11);
    chk("bw1_we", {15'h0, reg_we}, 16'h0001);
    chk("bw1_addr", {10'h0, reg_addr}, 16'h000F);
    chk("bw1_wdata", {8'h00, reg_wdata}, 16'h0011);
    tick();
    chk("bw_wrap", {10'h0, reg_addr}, 16'h0000);
    tick(6);
    send(8'h22);
    chk("bw2_we", {15'h0, reg_we}, 16'h0001);
    chk("bw2_addr", {10'h0, reg_addr}, 16'h0000);
    chk("bw2_wdata", {8'h00, reg_wdata}, 16'h0022);
    chk("bw_err", {15'h0, addr_err}, 16'h0000);
    tick();
    chk("bw2_addr_inc", {10'h0, reg_addr}, 16'h0001);
    frame_end();

    // Invalid write address 20
    frame_start();
    send(8'h94);
    chk("inv_err", {15'h0, addr_err}, 16'h0001);
    tick(7);
    send(8'h55);
    chk("inv_no_we", {15'h0, reg_we}, 16'h0000);
    tick();
    chk("inv_addr_inc", {10'h0, reg_addr}, 16'h0015);
    chk("inv_err_sticky", {15'h0, addr_err}, 16'h0001);
    frame_end();
    chk("inv_we_count", we_count[15:0], 16'd3);

    // Invalid read address 20 returns zero
    frame_start();
    send(8'h14);
    tick();
    chk("inv_rd_tx", {8'h00, tx_byte}, 16'h0000);
    chk("inv_rd_err", {15'h0, addr_err}, 16'h0001);
    frame_end();

    // Next valid command clears the flag
    frame_start();
    send(8'h01);
    chk("err_clear", {15'h0, addr_err}, 16'h0000);
    tick();
    chk("rd1_tx", {8'h00, tx_byte}, 16'h0001);
    frame_end();

    // Abort: write cmd to addr 2, cs_n high mid data byte
    frame_start();
    send(8'h82);
    tick(4);
    cs_n = 1'b1;
    tick(3);
    chk("abort_we", {15'h0, reg_we}, 16'h0000);
    frame_start();
    send(8'h05);
    chk("abort_rd_addr", {10'h0, reg_addr}, 16'h0005);
    chk("abort_rd_re", {15'h0, reg_re}, 16'h0001);
    tick();
    chk("abort_rd_tx", {8'h00, tx_byte}, 16'h007E);
    frame_end();
    chk("abort_we_count", we_count[15:0], 16'd3);

    // Reset mid-burst, then first byte is a command
    frame_start();
    send(8'h81);
    tick(7);
    send(8'h99);
    tick(3);
    rst_n = 1'b0;
    #2;
    chk_reset("rst_mid");
    tick();
    rst_n = 1'b1;
    tick();
    send(8'h47);
    chk("post_rst_re", {15'h0, reg_re}, 16'h0001);
    chk("post_rst_hi", {15'h0, reg_hi}, 16'h0001);
    tick();
    chk("post_rst_tx", {8'h00, tx_byte}, 16'h00A1);
    frame_end();

    chk("we_total", we_count[15:0], 16'd4);
    chk("we_re_excl", both_count[15:0], 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
